// File: rtl/l1d_write_buffer_if.sv
// Signal bundle between the L1 data cache port, the write buffer and the AXI master bridge.
// Handshakes: a cache request completes in a cycle with d_req=1 and d_wait=0; a bus operation
// completes in a cycle with (m_read|m_write)=1 and m_stall=0; requesters hold everything stable until then.
interface l1d_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TYPE_W = 3
);
    logic              d_req;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_in;
    logic [TYPE_W-1:0] d_type;
    logic [DATA_W-1:0] d_out;
    logic              d_wait;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [TYPE_W-1:0] m_type;
    logic [DATA_W-1:0] m_data_out;
    logic              m_stall;

    logic              wb_empty;

    // master: the write buffer itself; slave: the cache plus bridge around it
    modport master (
        input  d_req, d_write, d_addr, d_in, d_type, m_data_out, m_stall,
        output d_out, d_wait, m_read, m_write, m_addr, m_data, m_type, wb_empty
    );

    modport slave (
        output d_req, d_write, d_addr, d_in, d_type, m_data_out, m_stall,
        input  d_out, d_wait, m_read, m_write, m_addr, m_data, m_type, wb_empty
    );
endinterface

// File: rtl/l1d_write_buffer.sv
// Posted-write FIFO between the L1 data cache and the AXI master bridge. Writes retire at once
// and drain in the background; reads wait for all earlier writes, one bus operation at a time.
module l1d_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TYPE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    l1d_write_buffer_if.master  bus,
    output logic [1:0]          dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WDRAIN = 2'd1,
        S_RD     = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [TYPE_W-1:0] rd_type;
    logic [DATA_W-1:0] d_out_q;
    logic              enq, deq, rd_done, rd_latch;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [TYPE_W-1:0] fifo_type [DEPTH];

    // No bypass: a full buffer only accepts after a drain has actually lowered count
    assign enq     = bus.d_req & bus.d_write & (count != CNT_W'(DEPTH));
    assign deq     = (state == S_WDRAIN) & ~bus.m_stall;
    assign rd_done = (state == S_RD) & ~bus.m_stall;

    always_comb begin
        count_next = count;
        if (enq && !deq)
            count_next = count + CNT_W'(1);
        else if (!enq && deq)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= bus.d_addr;
            fifo_data[wr_ptr] <= bus.d_in;
            fifo_type[wr_ptr] <= bus.d_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rd_addr <= '0;
            rd_type <= '0;
            d_out_q <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (rd_latch) begin
                rd_addr <= bus.d_addr;
                rd_type <= bus.d_type;
            end
            if (rd_done)
                d_out_q <= bus.m_data_out;
        end
    end

    always_comb begin
        state_next  = state;
        rd_latch    = 1'b0;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.m_addr  = '0;
        bus.m_data  = '0;
        bus.m_type  = '0;
        bus.d_out   = d_out_q;
        case (state)
            S_IDLE: begin
                // A write posted this cycle counts, so its drain starts on the next cycle
                if (count != '0 || enq) begin
                    state_next = S_WDRAIN;
                end else if (bus.d_req && !bus.d_write) begin
                    state_next = S_RD;
                    rd_latch   = 1'b1;
                end
            end
            S_WDRAIN: begin
                bus.m_write = 1'b1;
                bus.m_addr  = fifo_addr[rd_ptr];
                bus.m_data  = fifo_data[rd_ptr];
                bus.m_type  = fifo_type[rd_ptr];
                if (!bus.m_stall && count_next == '0)
                    state_next = S_IDLE;
            end
            S_RD: begin
                bus.m_read = 1'b1;
                bus.m_addr = rd_addr;
                bus.m_type = rd_type;
                if (!bus.m_stall) begin
                    bus.d_out  = bus.m_data_out;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.d_wait = 1'b0;
        if (bus.d_req)
            bus.d_wait = bus.d_write ? (count == CNT_W'(DEPTH)) : ~rd_done;
    end

    assign bus.wb_empty = (count == '0) && (state == S_IDLE);
    assign dbg_state    = state;
endmodule

// File: tb/tb_l1d_write_buffer.sv
// Bench for l1d_write_buffer: a bridge model with a simple memory, a program-order reference
// memory, and a scoreboard that checks every bus write and every read completion.
module tb_l1d_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TW    = 3;
    localparam int EW    = AW + DW + TW;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    l1d_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW)) bus_if ();

    l1d_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int bus_wr_seen = 0;
    int stall_mode;     // 0 random, 1 always stalled, 2 never stalled
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] bus_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- bridge model + monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        case (stall_mode)
            1:       bus_if.m_stall = 1'b1;
            2:       bus_if.m_stall = 1'b0;
            default: bus_if.m_stall = 1'($urandom_range(0, 1));
        endcase
        if (bus_if.m_read)
            bus_if.m_data_out = bus_mem.exists(bus_if.m_addr) ? bus_mem[bus_if.m_addr] : dflt(bus_if.m_addr);
        else
            bus_if.m_data_out = $urandom;
        #1;
        if (!rst) begin
            if (bus_if.m_read || bus_if.m_write)
                check("bus_exclusive", bus_if.m_read & bus_if.m_write, 1'b0);
            if (bus_if.m_write && !bus_if.m_stall) begin
                bus_wr_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_write_unexpected: got addr %0h data %0h expected none", bus_if.m_addr, bus_if.m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_write", {bus_if.m_addr, bus_if.m_data, bus_if.m_type}, e);
                end
                bus_mem[bus_if.m_addr] = bus_if.m_data;
            end
            if (bus_if.m_read && !bus_if.m_stall) begin
                check("read_after_drain", exp_q.size(), 0);
                check("read_done_wait", bus_if.d_wait, 1'b0);
                if (exp_rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL read_unexpected: got d_out %0h expected none", bus_if.d_out);
                end else begin
                    check("read_data", bus_if.d_out, exp_rd_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [TW-1:0] t, output int waits);
        bit done = 0;
        waits = 0;
        bus_if.d_req = 1'b1; bus_if.d_write = 1'b1;
        bus_if.d_addr = a;   bus_if.d_in = d; bus_if.d_type = t;
        while (!done) begin
            @(negedge clk); #2;
            if (!bus_if.d_wait) begin
                exp_q.push_back({a, d, t});
                ref_mem[a] = d;
                done = 1;
            end else begin
                waits++;
                if (waits > 200) begin
                    timeout_fail("write_accept");
                    done = 1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int waits);
        bit done = 0;
        waits = 0;
        exp_rd_q.push_back(ref_mem.exists(a) ? ref_mem[a] : dflt(a));
        bus_if.d_req = 1'b1; bus_if.d_write = 1'b0;
        bus_if.d_addr = a;   bus_if.d_in = $urandom; bus_if.d_type = 3'd2;
        while (!done) begin
            @(negedge clk); #2;
            if (!bus_if.d_wait) begin
                done = 1;
            end else begin
                waits++;
                if (waits > 300) begin
                    timeout_fail("read_complete");
                    done = 1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        int n = 0;
        bus_if.d_req = 1'b0;
        while (!done) begin
            @(negedge clk); #2;
            if (bus_if.wb_empty) done = 1;
            else if (++n > 300) begin
                timeout_fail("wait_idle");
                done = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int seen;
        logic [DW-1:0] d5;
        rst = 1'b1;
        stall_mode = 2;
        bus_if.d_req = 1'b0; bus_if.d_write = 1'b0; bus_if.d_addr = '0;
        bus_if.d_in = '0;    bus_if.d_type = '0;
        bus_if.m_stall = 1'b0; bus_if.m_data_out = '0;

        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check("rst_d_wait",   bus_if.d_wait,   1'b0);
        check("rst_m_read",   bus_if.m_read,   1'b0);
        check("rst_m_write",  bus_if.m_write,  1'b0);
        check("rst_m_addr",   bus_if.m_addr,   '0);
        check("rst_m_data",   bus_if.m_data,   '0);
        check("rst_m_type",   bus_if.m_type,   '0);
        check("rst_wb_empty", bus_if.wb_empty, 1'b1);
        check("rst_d_out",    bus_if.d_out,    '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single posted write, bus stalled for two cycles
        stall_mode = 1;
        do_write(32'h0001_0004, 32'hDEAD_BEEF, 3'd2, w);
        check("single_post_wait", w, 0);
        bus_if.d_req = 1'b0;
        @(negedge clk); #2;
        check("single_m_write_c1", bus_if.m_write, 1'b1);
        check("single_bus_c1", {bus_if.m_addr, bus_if.m_data}, {32'h0001_0004, 32'hDEAD_BEEF});
        @(negedge clk); #2;
        check("single_busy_c2", {bus_if.m_write, bus_if.wb_empty}, 2'b10);
        stall_mode = 2;
        @(negedge clk); #2;
        check("single_m_write_c3", bus_if.m_write, 1'b1);
        @(negedge clk); #2;
        check("single_wb_empty_c4", bus_if.wb_empty, 1'b1);
        @(posedge clk); #1;

        // fill to full with the bus stalled, then release
        stall_mode = 1;
        for (int i = 0; i < DEPTH; i++) begin
            do_write(32'h100 + 32'(4 * i), $urandom, 3'd2, w);
            check("fill_accept_wait", w, 0);
        end
        d5 = $urandom;
        bus_if.d_req = 1'b1; bus_if.d_write = 1'b1;
        bus_if.d_addr = 32'h110; bus_if.d_in = d5; bus_if.d_type = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check("full_d_wait", bus_if.d_wait, 1'b1);
        end
        stall_mode = 2;
        @(posedge clk); #1;
        do_write(32'h110, d5, 3'd2, w);
        check("full_accept_wait", w, 1);
        wait_idle();

        // read-after-write ordering
        stall_mode = 0;
        do_write(32'h2000, 32'h55, 3'd2, w);
        do_read(32'h2000, w);
        wait_idle();

        // back-to-back writes across the pointer wrap, random stalls
        for (int i = 0; i < 10; i++)
            do_write(32'h4000 + 32'(4 * i), $urandom, 3'($urandom_range(0, 7)), w);

        // random mixed traffic
        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] a;
            a = 32'h3000 + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) do_read(a, w);
            else do_write(a, $urandom, 3'($urandom_range(0, 7)), w);
            if ($urandom_range(0, 2) == 0) begin
                bus_if.d_req = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        wait_idle();

        // empty-buffer read, no stall: completes in cycle 1
        stall_mode = 2;
        do_read(32'h8000_0000, w);
        check("empty_read_latency", w, 1);
        bus_if.d_req = 1'b0;
        @(negedge clk); #2;
        check("empty_read_m_read_c2", bus_if.m_read, 1'b0);
        @(posedge clk); #1;

        // reset while draining discards everything buffered
        stall_mode = 1;
        for (int i = 0; i < 3; i++)
            do_write(32'h5000 + 32'(4 * i), $urandom, 3'd2, w);
        bus_if.d_req = 1'b0;
        @(negedge clk); #2;
        check("pre_reset_m_write", bus_if.m_write, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_reset_bus", {bus_if.m_write, bus_if.m_read}, 2'b00);
        check("mid_reset_wb_empty", bus_if.wb_empty, 1'b1);
        exp_q.delete();
        ref_mem = bus_mem;
        @(posedge clk); #1;
        rst = 1'b0;
        stall_mode = 2;
        seen = bus_wr_seen;
        repeat (10) @(posedge clk);
        #1;
        check("no_write_after_reset", bus_wr_seen, seen);
        check("post_reset_wb_empty", bus_if.wb_empty, 1'b1);

        // traffic after reset still behaves
        stall_mode = 0;
        do_write(32'h4004, 32'h1234_5678, 3'd2, w);
        do_read(32'h4004, w);
        do_read(32'h4008, w);
        wait_idle();

        check("exp_q_drained", exp_q.size(), 0);
        check("exp_rd_q_drained", exp_rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
